// File: rtl/id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : id_stage                                                     |
// | Description : Registered RV32/RV64 decode stage with load-use and jump     |
// |               interlocks, sitting between IF and EX.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module id_stage #(
  parameter int XLEN             = 32,
  parameter int REG_ADDR_WIDTH   = 5,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               inst,
  input  logic [XLEN-1:0]           inst_addr,
  output logic [REG_ADDR_WIDTH-1:0] regs_addr1,
  output logic [REG_ADDR_WIDTH-1:0] regs_addr2,
  input  logic [XLEN-1:0]           regs_data1,
  input  logic [XLEN-1:0]           regs_data2,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_operand1,
  output logic [XLEN-1:0]           out_operand2,
  output logic [XLEN-1:0]           out_rs2_data,
  output logic [XLEN-1:0]           out_imm,
  output logic [REG_ADDR_WIDTH-1:0] out_rd,
  output logic                      out_rd_we,
  output logic [6:0]                out_opcode,
  output logic [2:0]                out_funct3,
  output logic [6:0]                out_funct7,
  output logic [XLEN-1:0]           out_inst_addr,
  output logic                      out_is_load,
  output logic                      out_illegal
);

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i      = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_system = 7'b1110011;
  localparam logic [1:0] c_bubbles   = 2'(LOAD_USE_BUBBLES);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_WAIT_JUMP = 1'b1} state_t;

  state_t                    r_state;
  logic [1:0]                r_bubble_cnt;
  logic [REG_ADDR_WIDTH-1:0] r_load_rd;

  logic [6:0]                w_opcode;
  logic [REG_ADDR_WIDTH-1:0] w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0]           w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [XLEN-1:0]           w_op1, w_op2, w_imm;
  logic                      w_use1, w_use2, w_wb, w_illegal;
  logic                      w_match_out, w_match_load, w_hazard, w_accept, w_is_jump;

  assign w_opcode = inst[6:0];
  assign w_rs1    = REG_ADDR_WIDTH'(inst[19:15]);
  assign w_rs2    = REG_ADDR_WIDTH'(inst[24:20]);
  assign w_rd     = REG_ADDR_WIDTH'(inst[11:7]);

  assign w_imm_i = XLEN'($signed(inst[31:20]));
  assign w_imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign w_imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign w_imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign w_imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  always_comb begin
    w_op1     = '0;
    w_op2     = '0;
    w_imm     = '0;
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_wb      = 1'b0;
    w_illegal = 1'b0;
    case (w_opcode)
      c_op_r: begin
        w_op1 = regs_data1; w_op2 = regs_data2;
        w_use1 = 1'b1; w_use2 = 1'b1; w_wb = 1'b1;
      end
      c_op_i, c_op_load, c_op_jalr: begin
        w_op1 = regs_data1; w_op2 = w_imm_i; w_imm = w_imm_i;
        w_use1 = 1'b1; w_wb = 1'b1;
      end
      c_op_store: begin
        w_op1 = regs_data1; w_op2 = regs_data2; w_imm = w_imm_s;
        w_use1 = 1'b1; w_use2 = 1'b1;
      end
      c_op_branch: begin
        w_op1 = regs_data1; w_op2 = regs_data2; w_imm = w_imm_b;
        w_use1 = 1'b1; w_use2 = 1'b1;
      end
      c_op_lui: begin
        w_op2 = w_imm_u; w_imm = w_imm_u; w_wb = 1'b1;
      end
      c_op_auipc: begin
        w_op1 = inst_addr; w_op2 = w_imm_u; w_imm = w_imm_u; w_wb = 1'b1;
      end
      c_op_jal: begin
        w_op1 = inst_addr; w_op2 = w_imm_j; w_imm = w_imm_j; w_wb = 1'b1;
      end
      c_op_system: ;
      default: w_illegal = 1'b1;
    endcase
  end

  assign regs_addr1 = w_use1 ? w_rs1 : '0;
  assign regs_addr2 = w_use2 ? w_rs2 : '0;

  // Only sources the instruction actually reads can create a dependency.
  assign w_match_out  = (w_use1 && (w_rs1 == out_rd)) || (w_use2 && (w_rs2 == out_rd));
  assign w_match_load = (w_use1 && (w_rs1 == r_load_rd)) || (w_use2 && (w_rs2 == r_load_rd));
  assign w_hazard     = (out_valid && out_is_load && out_rd_we && w_match_out) ||
                        ((r_bubble_cnt != 2'd0) && w_match_load);

  assign in_ready  = rst_n && (r_state == ST_RUN) && !flush && !w_hazard &&
                     (!out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_is_jump = (w_opcode == c_op_jal) || (w_opcode == c_op_jalr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_bubble_cnt  <= 2'd0;
      r_load_rd     <= '0;
      out_valid     <= 1'b0;
      out_operand1  <= '0;
      out_operand2  <= '0;
      out_rs2_data  <= '0;
      out_imm       <= '0;
      out_rd        <= '0;
      out_rd_we     <= 1'b0;
      out_opcode    <= '0;
      out_funct3    <= '0;
      out_funct7    <= '0;
      out_inst_addr <= '0;
      out_is_load   <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid    <= 1'b0;
      r_bubble_cnt <= 2'd0;
      r_state      <= ST_RUN;
    end else begin
      if (w_accept) begin
        out_valid     <= 1'b1;
        out_operand1  <= w_op1;
        out_operand2  <= w_op2;
        out_rs2_data  <= w_use2 ? regs_data2 : '0;
        out_imm       <= w_imm;
        out_rd        <= w_rd;
        out_rd_we     <= w_wb && (w_rd != '0);
        out_opcode    <= w_opcode;
        out_funct3    <= inst[14:12];
        out_funct7    <= inst[31:25];
        out_inst_addr <= inst_addr;
        out_is_load   <= (w_opcode == c_op_load);
        out_illegal   <= w_illegal;
        if (w_is_jump) r_state <= ST_WAIT_JUMP;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A departing load arms the bubble counter against its destination.
      if (out_valid && out_ready && out_is_load && out_rd_we) begin
        r_load_rd    <= out_rd;
        r_bubble_cnt <= c_bubbles;
      end else if (r_bubble_cnt != 2'd0) begin
        r_bubble_cnt <= r_bubble_cnt - 2'd1;
      end
    end
  end

endmodule
`default_nettype wire
